ours_vld_rdy_rr_arb: RTL
========================

OURS_VLD_RDY_RR_ARB -- requirements
Module: ours_vld_rdy_rr_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters, legal 2..16.
REQ-002 SHALL have parameter WIDTH, default 32, info width per beat.
REQ-003 SHALL have parameter SRC_W, default $clog2(N_REQ), source-id width.
REQ-004 SHALL have port clk, input, 1, the only clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port slave_valid, input, N_REQ, per-requester valid.
REQ-007 SHALL have port slave_info, input, N_REQ*WIDTH, per-requester info; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port slave_last, input, N_REQ, last beat of packet per requester.
REQ-009 SHALL have port slave_ready, output, N_REQ, per-requester ready.
REQ-010 SHALL have ports master_valid (output, 1), master_info (output, WIDTH), master_last (output, 1), master_src (output, SRC_W, winning requester index), master_ready (input, 1).
REQ-011 SHALL have port clk_en, output, 1, high when the block needs its clock.

Function
REQ-012 SHALL arbitrate round-robin: search starts at pointer ptr, and the lowest index at or after ptr (mod N_REQ) with slave_valid high wins.
REQ-013 SHALL assert slave_ready[i] only for the granted requester, and only when the output buffer is not full; all other bits are 0. Grant is combinational from slave_valid.
REQ-014 SHALL accept a beat when slave_valid[i] & slave_ready[i]. It SHALL push {info, last, src=i} into a 2-entry output FIFO.
REQ-015 SHALL drive master_valid = FIFO not empty, with master_info, master_last and master_src taken from the FIFO head. Pop SHALL occur when master_valid & master_ready.
REQ-016 SHALL have latency exactly 1 cycle: a beat accepted at edge t appears on master_* after edge t, if the FIFO was empty.
REQ-017 SHALL sustain one beat per cycle when master_ready is held high. A push and a pop SHALL be allowed in the same cycle when the FIFO is full.
REQ-018 SHALL set ptr to (i+1) mod N_REQ on acceptance of a beat from i with slave_last=1. In unlocked mode (REQ-026) this happens on every accepted beat.
REQ-019 SHALL use lock FSM states IDLE and LOCKED.
- IDLE->LOCKED: a beat from i is accepted with slave_last=0; lock_id=i is stored.
- LOCKED->IDLE: the beat from lock_id is accepted with slave_last=1.
- In LOCKED, grant is forced to lock_id even if slave_valid[lock_id]=0; other requesters wait.
REQ-020 SHALL generate no grant when no slave_valid bit is set in IDLE; ptr is held.
REQ-021 SHALL drive clk_en = rst | (|slave_valid) | FIFO not empty | state==LOCKED.
REQ-022 SHALL hold master_* stable while master_valid=1 and master_ready=0.

Reset
REQ-023 SHALL, while rst=1, asynchronously clear: FIFO empty, ptr=0, state=IDLE, lock_id=0.
REQ-024 SHALL drive these reset values on outputs: master_valid=0, master_info=0, master_last=0, master_src=0, slave_ready=0.
REQ-025 SHALL discard any in-flight packet and buffered beats on reset mid-operation; no beat is replayed after release.

Configuration
REQ-026 SHALL compile packet lock in only when macro OURS_VLD_RDY_ARB_LOCK_EN is defined.
- Defined: REQ-019 applies.
- Undefined: no lock FSM; slave_last is passed through to master_last only; arbitration is per beat; ptr advances on every accepted beat.

Verification
REQ-027 N_REQ=4, all valid=1, last=1, master_ready=1 -> master_src sequence 0,1,2,3,0; one beat per cycle.
REQ-028 Lock enabled; req1 sends 3 beats (last=0,0,1) while req2 valid -> master_src 1,1,1 then 2; req2 is not granted during the packet.
REQ-029 master_ready=0 for 4 cycles, req0 valid -> exactly 2 beats accepted, slave_ready[0]=0 afterwards; master_info unchanged until ready.
REQ-030 Lock enabled; req3 beat last=0 accepted, then slave_valid[3]=0 for 2 cycles with req0 valid -> slave_ready[0]=0 until req3 sends last=1.
REQ-031 rst pulsed while LOCKED with 2 beats buffered -> master_valid=0 immediately, ptr=0, next grant goes to the lowest valid index.
REQ-032 Lock disabled, same stimulus as REQ-028 -> master_src 1,2,1,2,1, interleaved.

Source files
------------

// File: rtl/ours_vld_rdy_rr_arb.sv
// Round-robin valid/ready arbiter feeding a 2-entry output FIFO.
// Define OURS_VLD_RDY_ARB_LOCK_EN to hold the grant for a whole packet (until slave_last).
module ours_vld_rdy_rr_arb #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SRC_W = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       slave_valid,
   input  logic [N_REQ*WIDTH-1:0] slave_info,
   input  logic [N_REQ-1:0]       slave_last,
   output logic [N_REQ-1:0]       slave_ready,
   output logic                   master_valid,
   output logic [WIDTH-1:0]       master_info,
   output logic                   master_last,
   output logic [SRC_W-1:0]       master_src,
   input  logic                   master_ready,
   output logic                   clk_en
);

   localparam int unsigned ENT_W = WIDTH + 1 + SRC_W;

   logic [ENT_W-1:0] mem_q [2];
   logic             rd_q, wr_q;
   logic [1:0]       cnt_q, cnt_d;
   logic [SRC_W-1:0] ptr_q, ptr_d;
   logic             fifo_empty, fifo_full, push, pop, space;

   logic             rr_vld;
   logic [SRC_W-1:0] rr_id;
   logic [SRC_W:0]   cand;
   logic             gnt_vld;
   logic [SRC_W-1:0] gnt_id;
   logic [SRC_W:0]   nxt_w;
   logic [SRC_W-1:0] nxt_id;
   logic [WIDTH-1:0] gnt_info;
   logic             gnt_last;
   logic             locked;

   assign fifo_empty = (cnt_q == 2'd0);
   assign fifo_full  = (cnt_q == 2'd2);
   // A full FIFO can still take a beat when its head leaves in the same cycle.
   assign space      = !fifo_full || master_ready;
   assign pop        = !fifo_empty && master_ready;

   always_comb begin
      rr_vld = 1'b0;
      rr_id  = '0;
      cand   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr_q} + (SRC_W+1)'(k);
         if (cand >= (SRC_W+1)'(N_REQ))
            cand = cand - (SRC_W+1)'(N_REQ);
         if (!rr_vld && slave_valid[cand[SRC_W-1:0]]) begin
            rr_vld = 1'b1;
            rr_id  = cand[SRC_W-1:0];
         end
      end
   end

`ifdef OURS_VLD_RDY_ARB_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t           state_q, state_d;
   logic [SRC_W-1:0] lock_id_q, lock_id_d;

   assign locked  = (state_q == LOCKED);
   assign gnt_vld = locked ? 1'b1 : rr_vld;
   assign gnt_id  = locked ? lock_id_q : rr_id;
`else
   assign locked  = 1'b0;
   assign gnt_vld = rr_vld;
   assign gnt_id  = rr_id;
`endif

   always_comb begin
      gnt_info = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt_id == SRC_W'(i))
            gnt_info = slave_info[i*WIDTH +: WIDTH];
      end
   end

   assign gnt_last = slave_last[gnt_id];

   always_comb begin
      slave_ready = '0;
      if (gnt_vld && space && !rst)
         slave_ready[gnt_id] = 1'b1;
   end

   assign push = gnt_vld && space && !rst && slave_valid[gnt_id];

   always_comb begin
      nxt_w  = {1'b0, gnt_id} + (SRC_W+1)'(1);
      nxt_id = (nxt_w == (SRC_W+1)'(N_REQ)) ? '0 : nxt_w[SRC_W-1:0];
   end

`ifdef OURS_VLD_RDY_ARB_LOCK_EN
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      ptr_d     = ptr_q;
      if (push) begin
         case (state_q)
            IDLE: begin
               if (gnt_last) begin
                  ptr_d = nxt_id;
               end else begin
                  state_d   = LOCKED;
                  lock_id_d = gnt_id;
               end
            end
            LOCKED: begin
               if (gnt_last) begin
                  state_d = IDLE;
                  ptr_d   = nxt_id;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
      end
   end
`else
   assign ptr_d = push ? nxt_id : ptr_q;
`endif

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         cnt_q    <= '0;
         ptr_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= {gnt_info, gnt_last, gnt_id};
            wr_q        <= ~wr_q;
         end
         if (pop)
            rd_q <= ~rd_q;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      {master_info, master_last, master_src} = mem_q[rd_q];
   end

   assign master_valid = !fifo_empty;
   assign clk_en       = rst || (|slave_valid) || !fifo_empty || locked;

endmodule
